// File: rtl/aes_frame_ram.sv
// Word RAM holding RS232 character frames; a controller gathers a frame, runs it through an
// external AES core and writes the ciphertext words plus a terminator back in place.
module aes_frame_ram #(
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned TIMEOUT   = 1023,
    parameter logic [31:0] TERM_WORD = 32'hFFFFFFFF,
    parameter logic [31:0] ERR_WORD  = 32'h00000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              action,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              rdy,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              aes_start,
    output logic              aes_mode,
    output logic [127:0]      aes_din,
    input  logic [127:0]      aes_dout,
    input  logic              aes_done
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GATHER = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ABORT  = 3'd6;

    function automatic logic [31:0] unpack7(input logic [27:0] s);
        return {1'b1, s[27:21], 1'b1, s[20:14], 1'b1, s[13:7], 1'b1, s[6:0]};
    endfunction

    logic [31:0] mem [DEPTH];

    logic [2:0]   state_q, state_d;
    logic [2:0]   cnt_q;
    logic [31:0]  tmo_q;
    logic [31:0]  base_q;
    logic [31:0]  rd_q;
    logic [127:0] ct_q;
    logic         err_q;

    logic [31:0]  addr_ext, frame_base;
    logic         host_ok, host_wr, in_range, trig, trig_fits;
    logic [31:0]  rd_word, wr_word, mem_wd;
    logic [IW-1:0] mem_ra, mem_wa;
    logic         mem_we;
    logic [27:0]  rd_pack;
    logic         unused_rd;

    assign addr_ext   = 32'(addr);
    assign frame_base = addr_ext - (addr_ext % 32'd12);
    assign host_ok    = en && (state_q == S_IDLE);
    assign host_wr    = host_ok && action;
    assign in_range   = addr_ext < DEPTH;
    assign trig       = host_wr && ((addr_ext % 32'd12) == 32'd5);
    assign trig_fits  = (frame_base + 32'd11) < DEPTH;

    // Separator bits [31], [23], [15], [7] of each input word never reach the AES block.
    assign rd_pack   = {rd_q[30:24], rd_q[22:16], rd_q[14:8], rd_q[6:0]};
    assign unused_rd = ^{rd_q[31], rd_q[23], rd_q[15], rd_q[7]};

    assign rdy       = (state_q == S_IDLE);
    assign busy      = !rdy;
    assign done      = (state_q == S_DONE);
    assign err       = err_q || (state_q == S_ABORT);
    assign aes_start = (state_q == S_START);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (trig && trig_fits) state_d = S_GATHER;
            S_GATHER: if (cnt_q == 3'd5) state_d = S_START;
            S_START:  state_d = S_WAIT;
            S_WAIT: begin
                if (aes_done) state_d = S_WRITE;
                else if (tmo_q == TIMEOUT) state_d = S_ABORT;
            end
            S_WRITE:  if (cnt_q == 3'd5) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            S_ABORT:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_word = TERM_WORD;
        case (cnt_q)
            3'd0: wr_word = unpack7(ct_q[27:0]);
            3'd1: wr_word = unpack7(ct_q[55:28]);
            3'd2: wr_word = unpack7(ct_q[83:56]);
            3'd3: wr_word = unpack7(ct_q[111:84]);
            3'd4: wr_word = {8'h80, 1'b1, 5'b0, ct_q[127:126], 1'b1, ct_q[125:119],
                             1'b1, ct_q[118:112]};
            default: wr_word = TERM_WORD;
        endcase
    end

    // One shared read port: gather reads in GATHER, host reads otherwise.
    always_comb begin
        mem_ra = (state_q == S_GATHER) ? IW'(base_q + 32'(cnt_q)) : IW'(addr_ext);
        mem_we = 1'b0;
        mem_wa = IW'(addr_ext);
        mem_wd = data_in;
        if (host_wr && in_range) begin
            mem_we = 1'b1;
        end else if (state_q == S_WRITE) begin
            mem_we = 1'b1;
            mem_wa = IW'(base_q + 32'd6 + 32'(cnt_q));
            mem_wd = wr_word;
        end else if (state_q == S_ABORT) begin
            mem_we = 1'b1;
            mem_wa = IW'(base_q + 32'd11);
            mem_wd = ERR_WORD;
        end
    end

    assign rd_word = mem[mem_ra];

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            tmo_q    <= 32'd0;
            base_q   <= 32'd0;
            rd_q     <= 32'd0;
            ct_q     <= 128'd0;
            err_q    <= 1'b0;
            data_out <= 32'd0;
            aes_mode <= 1'b0;
            aes_din  <= 128'd0;
        end else begin
            state_q <= state_d;
            err_q   <= trig && !trig_fits;
            if (host_ok && !action) data_out <= in_range ? rd_word : 32'd0;
            if (trig) aes_mode <= data_in[0];
            if (trig && trig_fits) base_q <= frame_base;
            case (state_q)
                S_GATHER: begin
                    rd_q  <= rd_word;
                    cnt_q <= (cnt_q == 3'd5) ? 3'd0 : cnt_q + 3'd1;
                    case (cnt_q)
                        3'd1: aes_din[27:0]    <= rd_pack;
                        3'd2: aes_din[55:28]   <= rd_pack;
                        3'd3: aes_din[83:56]   <= rd_pack;
                        3'd4: aes_din[111:84]  <= rd_pack;
                        3'd5: aes_din[127:112] <= {rd_q[17:16], rd_q[14:8], rd_q[6:0]};
                        default: ;
                    endcase
                end
                S_START: tmo_q <= 32'd0;
                S_WAIT: begin
                    tmo_q <= tmo_q + 32'd1;
                    if (aes_done) ct_q <= aes_dout;
                end
                S_WRITE: cnt_q <= (cnt_q == 3'd5) ? 3'd0 : cnt_q + 3'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_frame_ram.sv
// Directed bench for aes_frame_ram with a behavioural AES responder of programmable latency.
module tb_aes_frame_ram;

    logic         clk, rst, en, action;
    logic [6:0]   addr;
    logic [31:0]  data_in, data_out;
    logic         rdy, busy, done, err, aes_start, aes_mode, aes_done;
    logic [127:0] aes_din, aes_dout;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc = 0, done_cnt = 0, err_cnt = 0, start_cnt = 0, done_cyc = 0, last_wr_cyc = 0;
    int aes_lat = 10, cd = 0;
    logic         aes_en = 1'b1, stray = 1'b0, got_mode = 1'b0;
    logic [127:0] aes_res = '0, got_din = '0;
    logic [31:0]  rd;
    int d0, e0, s0;

    aes_frame_ram dut (
        .clk(clk), .rst(rst), .en(en), .action(action), .addr(addr), .data_in(data_in),
        .data_out(data_out), .rdy(rdy), .busy(busy), .done(done), .err(err),
        .aes_start(aes_start), .aes_mode(aes_mode), .aes_din(aes_din),
        .aes_dout(aes_dout), .aes_done(aes_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err) err_cnt++;
    end

    // AES responder: aes_done rises aes_lat cycles after the cycle aes_start is seen.
    initial begin
        aes_done = 1'b0;
        aes_dout = '0;
        forever begin
            @(negedge clk);
            aes_done = 1'b0;
            if (stray) aes_done = 1'b1;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    aes_done = 1'b1;
                    aes_dout = aes_res;
                end
            end
            if (aes_start) begin
                start_cnt++;
                got_din  = aes_din;
                got_mode = aes_mode;
                if (aes_en) cd = aes_lat;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic host_wr(input logic [6:0] a, input logic [31:0] d);
        @(negedge clk);
        en = 1'b1; action = 1'b1; addr = a; data_in = d;
        last_wr_cyc = cyc;
        @(negedge clk);
        en = 1'b0; action = 1'b0;
    endtask

    task automatic host_rd(input logic [6:0] a, output logic [31:0] d);
        @(negedge clk);
        en = 1'b1; action = 1'b0; addr = a;
        @(negedge clk);
        en = 1'b0;
        d = data_out;
    endtask

    task automatic rd_chk(input string tag, input logic [6:0] a, input logic [31:0] exp);
        logic [31:0] v;
        host_rd(a, v);
        check(tag, 128'(v), 128'(exp));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 128'(busy), 128'(1'b0));
    endtask

    task automatic load_frame(input logic [6:0] b, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input logic [31:0] w4);
        host_wr(b, w0);
        host_wr(b + 7'd1, w1);
        host_wr(b + 7'd2, w2);
        host_wr(b + 7'd3, w3);
        host_wr(b + 7'd4, w4);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; action = 1'b0; addr = '0; data_in = '0;
        repeat (3) @(negedge clk);
        check("rst_data_out", 128'(data_out), 128'(0));
        check("rst_rdy", 128'(rdy), 128'(1));
        check("rst_outs", 128'({busy, done, err, aes_start, aes_mode}), 128'(0));
        check("rst_din", aes_din, 128'd0);
        rst = 1'b0;

        // 1: all-zero frame, AES returns all ones after 10 cycles
        load_frame(7'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        aes_res = '1; aes_lat = 10; d0 = done_cnt;
        host_wr(7'd5, 32'h0);
        wait_idle("t1_idle", 200);
        check("t1_din", got_din, 128'd0);
        check("t1_mode", 128'(got_mode), 128'(0));
        check("t1_latency", 128'(done_cyc - last_wr_cyc), 128'(24));
        check("t1_done_cnt", 128'(done_cnt - d0), 128'(1));
        rd_chk("t1_w6", 7'd6, 32'hFFFFFFFF);
        rd_chk("t1_w9", 7'd9, 32'hFFFFFFFF);
        rd_chk("t1_w10", 7'd10, 32'h8083FFFF);
        rd_chk("t1_w11", 7'd11, 32'hFFFFFFFF);

        // 2: edge characters, AES returns zero
        load_frame(7'd0, 32'h0000007F, 32'h0, 32'h0, 32'h0, 32'h00030000);
        aes_res = '0;
        host_wr(7'd5, 32'h0);
        wait_idle("t2_idle", 200);
        check("t2_din", got_din, {2'b11, 119'd0, 7'h7F});
        rd_chk("t2_w6", 7'd6, 32'h80808080);
        rd_chk("t2_w8", 7'd8, 32'h80808080);
        rd_chk("t2_w10", 7'd10, 32'h80808080);

        // 3: frame 1, decrypt, separator bits set in the inputs
        load_frame(7'd12, 32'h01020304, 32'h0, 32'h0, 32'h80808080, 32'hFFFC0000);
        aes_res = 128'h80000000_00000000_00000000_10000001;
        host_wr(7'd17, 32'h1);
        wait_idle("t3_idle", 200);
        check("t3_mode", 128'(got_mode), 128'(1));
        check("t3_din", got_din, 128'h0208184);
        rd_chk("t3_w18", 7'd18, 32'h80808081);
        rd_chk("t3_w19", 7'd19, 32'h80808081);
        rd_chk("t3_w20", 7'd20, 32'h80808080);
        rd_chk("t3_w22", 7'd22, 32'h80828080);
        rd_chk("t3_w23", 7'd23, 32'hFFFFFFFF);
        rd_chk("t3_f0_w6", 7'd6, 32'h80808080);
        rd_chk("t3_f0_w11", 7'd11, 32'hFFFFFFFF);

        // 4: AES never answers
        aes_en = 1'b0; d0 = done_cnt; e0 = err_cnt;
        host_wr(7'd5, 32'h0);
        wait_idle("t4_idle", 1500);
        check("t4_err_cnt", 128'(err_cnt - e0), 128'(1));
        check("t4_done_cnt", 128'(done_cnt - d0), 128'(0));
        check("t4_rdy", 128'(rdy), 128'(1));
        rd_chk("t4_w11", 7'd11, 32'h00000000);
        rd_chk("t4_w6", 7'd6, 32'h80808080);
        rd_chk("t4_w10", 7'd10, 32'h80808080);

        // 5: host accesses while busy, then a trigger in a frame that does not fit
        aes_en = 1'b1; aes_lat = 30; aes_res = '0;
        rd_chk("t5_pre", 7'd11, 32'h0);
        host_wr(7'd5, 32'h0);
        check("t5_rdy_busy", 128'(rdy), 128'(0));
        host_wr(7'd2, 32'h12345678);
        host_rd(7'd6, rd);
        check("t5_dout_hold", 128'(rd), 128'(0));
        wait_idle("t5_idle", 200);
        rd_chk("t5_w2", 7'd2, 32'h0);
        e0 = err_cnt; s0 = start_cnt;
        host_wr(7'd125, 32'h0);
        repeat (3) @(negedge clk);
        check("t5_far_err", 128'(err_cnt - e0), 128'(1));
        check("t5_far_busy", 128'(busy), 128'(0));
        repeat (10) @(negedge clk);
        check("t5_far_start", 128'(start_cnt - s0), 128'(0));
        rd_chk("t5_w6", 7'd6, 32'h80808080);

        // 6: reset during WAIT, stray aes_done, then a clean run
        aes_en = 1'b0; d0 = done_cnt; e0 = err_cnt;
        host_wr(7'd5, 32'h0);
        repeat (12) @(negedge clk);
        check("t6_in_wait", 128'(busy), 128'(1));
        rst = 1'b1;
        #1;
        check("t6_rst_busy", 128'(busy), 128'(0));
        check("t6_rst_start", 128'(aes_start), 128'(0));
        check("t6_rst_outs", 128'({rdy, data_out, aes_mode}), 128'({1'b1, 32'h0, 1'b0}));
        check("t6_rst_din", aes_din, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        stray = 1'b1;
        repeat (2) @(negedge clk);
        stray = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_stray_busy", 128'(busy), 128'(0));
        check("t6_no_pulse", 128'({done_cnt - d0, err_cnt - e0}), 128'(0));
        aes_en = 1'b1; aes_lat = 5; aes_res = '1;
        host_wr(7'd5, 32'h0);
        wait_idle("t6_idle", 200);
        check("t6_done_cnt", 128'(done_cnt - d0), 128'(1));
        rd_chk("t6_w6", 7'd6, 32'hFFFFFFFF);
        rd_chk("t6_w10", 7'd10, 32'h8083FFFF);
        rd_chk("t6_w11", 7'd11, 32'hFFFFFFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
